// File: rtl/lpif_rxfifo_quarter_buf.sv
`default_nettype none
// ============================================================================
// Module   : lpif_rxfifo_quarter_buf
// Brief    : Credit-managed receive FIFO feeding the x4 asym2 quarter-rate
//            LPIF unpacker; first-word fall-through, one credit per pop.
// Revision : 1.0 - initial release
// ============================================================================
module lpif_rxfifo_quarter_buf #(
    parameter int WIDTH  = 308,
    parameter int DEPTH  = 8,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk_wr,
    input  logic              rst_wr,
    input  logic              rx_online,
    input  logic [WIDTH-1:0]  rxfifo_push_data,
    input  logic              rxfifo_push_vld,
    output logic [WIDTH-1:0]  rxfifo_downstream_data,
    output logic              rxfifo_downstream_vld,
    input  logic              rxfifo_downstream_rdy,
    output logic              rx_credit_return,
    output logic [AWIDTH:0]   fifo_count,
    output logic              overflow_err,
    output logic              push_offline_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INIT   = 2'd1,
        S_ACTIVE = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    localparam logic [AWIDTH:0]   c_CNT_FULL  = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0]   c_CNT_ONE   = (AWIDTH+1)'(1);
    localparam logic [AWIDTH-1:0] c_PTR_ONE   = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] c_INIT_LAST = AWIDTH'(DEPTH - 1);

    state_t              r_state;
    logic [AWIDTH-1:0]   r_wr_ptr;
    logic [AWIDTH-1:0]   r_rd_ptr;
    logic [AWIDTH-1:0]   r_init_cnt;
    logic [AWIDTH:0]     r_count;
    logic                r_credit;
    logic                r_overflow;
    logic                r_offline;
    logic [WIDTH-1:0]    r_mem [DEPTH];

    logic                w_active;
    logic                w_vld;
    logic                w_full;
    logic                w_pop;
    logic                w_push_ok;
    logic                w_drop_full;
    logic                w_drop_offline;

    assign w_active       = (r_state == S_ACTIVE);
    assign w_vld          = w_active && (r_count != '0);
    assign w_full         = (r_count == c_CNT_FULL);
    assign w_pop          = w_vld && rxfifo_downstream_rdy;
    // A pop on the same edge frees the slot, so a push into a full FIFO is legal then.
    assign w_push_ok      = w_active && rxfifo_push_vld && (!w_full || w_pop);
    assign w_drop_full    = w_active && rxfifo_push_vld && w_full && !w_pop;
    assign w_drop_offline = !w_active && rxfifo_push_vld;

    always_ff @(posedge clk_wr) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= rxfifo_push_data;
        end
    end

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_init_cnt <= '0;
            r_count    <= '0;
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
            r_offline  <= 1'b0;
        end else begin
            r_credit <= 1'b0;
            if (w_drop_full) begin
                r_overflow <= 1'b1;
            end
            if (w_drop_offline) begin
                r_offline <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (rx_online) begin
                        r_state    <= S_INIT;
                        r_init_cnt <= c_INIT_LAST;
                    end
                end

                S_INIT: begin
                    // Link loss abandons the remaining initial credits.
                    if (!rx_online) begin
                        r_state <= S_FLUSH;
                    end else begin
                        r_credit <= 1'b1;
                        if (r_init_cnt == '0) begin
                            r_state <= S_ACTIVE;
                        end else begin
                            r_init_cnt <= r_init_cnt - c_PTR_ONE;
                        end
                    end
                end

                S_ACTIVE: begin
                    r_credit <= w_pop;
                    if (w_push_ok) begin
                        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                    end
                    case ({w_push_ok, w_pop})
                        2'b10:   r_count <= r_count + c_CNT_ONE;
                        2'b01:   r_count <= r_count - c_CNT_ONE;
                        default: r_count <= r_count;
                    endcase
                    if (!rx_online) begin
                        r_state <= S_FLUSH;
                    end
                end

                S_FLUSH: begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stale memory is masked so the head word reads zero whenever nothing is valid.
    assign rxfifo_downstream_data = w_vld ? r_mem[r_rd_ptr] : '0;
    assign rxfifo_downstream_vld  = w_vld;
    assign rx_credit_return       = r_credit;
    assign fifo_count             = r_count;
    assign overflow_err           = r_overflow;
    assign push_offline_err       = r_offline;

endmodule
`default_nettype wire

// File: doc/lpif_rxfifo_quarter_buf.md
Name: lpif_rxfifo_quarter_buf

Overview:
- Receive-side buffer directly upstream of the x4 asym2 quarter-rate slave LPIF unpacker.
- Accepts 308-bit packed downstream words from the logic-link receive path and buffers them in a credit-managed FIFO.
- Presents the head word as rxfifo_downstream_data, with a valid/ready handshake, to the unpacker and adapter.
- Returns one credit to the far side per word popped.

Parameters:
- WIDTH, 308, packed word width (4 x 77-bit quarter slices).
- DEPTH, 8, FIFO entries; power of two, minimum 2, maximum 64.
- AWIDTH, $clog2(DEPTH), pointer width.

Ports:
- clk_wr  input  1  fabric clock; all logic is on its rising edge.
- rst_wr  input  1  asynchronous active-high reset.
- rx_online  input  1  link-up qualifier from the AIB/LLink control.
- rxfifo_push_data  input  WIDTH  received packed word.
- rxfifo_push_vld  input  1  push strobe; no backpressure.
- rxfifo_downstream_data  output  WIDTH  head-of-FIFO word.
- rxfifo_downstream_vld  output  1  head word valid.
- rxfifo_downstream_rdy  input  1  consumer accepts the head word.
- rx_credit_return  output  1  one-cycle pulse, one credit per pulse.
- fifo_count  output  AWIDTH+1  current occupancy, 0..DEPTH.
- overflow_err  output  1  sticky: a push was dropped while full.
- push_offline_err  output  1  sticky: a push arrived while not ACTIVE.

Behaviour:
- Reset values: all outputs 0, rxfifo_downstream_data 0, pointers 0, state IDLE.
- State machine (2-bit):
  - IDLE: waits for rx_online=1, then goes to INIT.
  - INIT: one rx_credit_return pulse per cycle for DEPTH cycles (init counter DEPTH-1 down to 0), then goes to ACTIVE.
  - ACTIVE: normal push and pop.
  - FLUSH: a single cycle that clears pointers and count, then returns to IDLE.
  - rx_online=0 in INIT or ACTIVE goes to FLUSH on the next edge. A partial credit burst is abandoned. Sticky flags are not cleared.
- Push (ACTIVE only):
  - rxfifo_push_vld=1 and not full: word written at wr_ptr, wr_ptr+1 (wraps modulo DEPTH).
  - The word is visible at rxfifo_downstream_data/vld on the cycle after the push edge (first-word fall-through, 1-cycle latency).
- Pop: rxfifo_downstream_vld & rxfifo_downstream_rdy on an edge advances rd_ptr, decrements count and pulses rx_credit_return on the next cycle (registered).
- rxfifo_downstream_vld = (count != 0) and state==ACTIVE. Data is held stable while vld=1 and rdy=0.
- Simultaneous push and pop:
  - Count unchanged; both pointers advance.
  - Legal when full: the pop frees a slot in the same edge, so the push is accepted and overflow_err is not set.
  - When empty, only the push takes effect (vld was 0).
- Full (count==DEPTH) with push and no pop: word dropped, overflow_err set to 1, count stays DEPTH.
- Push in IDLE, INIT or FLUSH: word dropped, push_offline_err set to 1.
- Credit invariant in ACTIVE: credits issued since INIT minus words pushed equals DEPTH - count. No credit is issued for dropped words.
- rx_credit_return during INIT and pop-driven pulses never coincide, because pops are impossible in INIT.
- Sticky flags clear only on rst_wr.
- Reset mid-operation: asynchronous reset immediately forces all of the above reset values. Memory contents need not be cleared; they are masked by count=0.
- fifo_count arithmetic is unsigned, AWIDTH+1 bits, and never exceeds DEPTH.

Test Plan:
- Bring-up: rst_wr 1->0, then rx_online=1 -> rx_credit_return high for exactly 8 consecutive cycles, starting 1 cycle after entering INIT, then state ACTIVE with fifo_count=0.
- Single word: push 308'h1 in ACTIVE with rdy=0 -> next cycle vld=1, data=308'h1, count=1. Assert rdy for 1 cycle -> vld=0, count=0, one credit pulse the cycle after.
- Fill and overflow: 9 back-to-back pushes (values 1..9) with rdy=0 -> count=8, overflow_err=1. Then drain with rdy=1 -> outputs 1..8 in order, 8 credit pulses.
- Full with simultaneous push and pop: at count=8, push 308'hA and pop on the same edge -> count=8, overflow_err stays 0, and 308'hA emerges 8th.
- Link drop: at count=5, rx_online=0 -> FLUSH then IDLE, vld=0, count=0. A push in IDLE sets push_offline_err=1. Re-assert rx_online -> 8 fresh credits.
- Async reset mid-burst: assert rst_wr between edges during INIT credit cycle 3 -> rx_credit_return drops to 0 immediately with no clock edge, and all outputs read 0.
